uart_tx_baud: RTL

UART transmitter with a run-time programmable bit period, the consumer side of the baud-latch interface driven by `init_ctrl`. It captures `baud_word` on each `latch_baud` pulse and serialises bytes from a valid/ready source onto `txd`. It transmits nothing until the first baud word has been latched. One instance sits behind each `latch_baud0/baud_word0` and `latch_baud1/baud_word1` pair.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_baud_if.sv | 12 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_tx_baud.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the baud-programmable UART transmitter and
// the matching receiver. Holds the parity-mode encodings, FSM state
// encodings, the baud-word width and a parity helper.
package uart_pkg;

   localparam int BAUD_W = 16;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Parity over the low nbits of data only; odd mode inverts the XOR so the
   // total count of ones (data + parity) is odd.
   function automatic logic calc_parity(input logic [7:0] data, input int nbits,
                                        input int mode);
      logic x;
      x = 1'b0;
      for (int i = 0; i < 8; i++)
         if (i < nbits) x = x ^ data[i];
      return (mode == int'(PAR_ODD)) ? ~x : x;
   endfunction

endpackage

// File: rtl/uart_tx_baud_if.sv
// uart_tx_baud_if: byte stream handshake into the transmitter.
//   tx_data  : byte to send (low DATA_BITS used)
//   tx_valid : source has a byte
//   tx_ready : transmitter accepts a byte this cycle
interface uart_tx_baud_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period down-counter.
//   clk, rst    : clock, async active-low reset
//   divisor_i   : bit period minus one
//   run_i       : count while high
//   restart_i   : reload from divisor_i (start of a frame)
//   bit_end_o   : strobe on the last cycle of each bit period
module uart_baud_tick
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BAUD_W-1:0] divisor_i,
   input  logic              run_i,
   input  logic              restart_i,
   output logic              bit_end_o
);

   logic [BAUD_W-1:0] cnt_q, cnt_d;

   assign bit_end_o = run_i && !restart_i && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i)
         cnt_d = divisor_i;
      else if (run_i)
         cnt_d = (cnt_q == '0) ? divisor_i : cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '1;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_baud.sv
// uart_tx_baud: UART transmitter with a run-time programmable bit period.
//   clk, rst   : clock, async active-low reset
//   latch_baud : strobe, capture baud_word (bit period minus one)
//   baud_word  : new divisor
//   baud_set   : a divisor has been applied since reset
//   tx         : byte stream handshake (slave side)
//   txd        : serial line, idles high
//   busy       : frame in progress
module uart_tx_baud
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              latch_baud,
   input  logic [BAUD_W-1:0] baud_word,
   output logic              baud_set,
   uart_tx_baud_if.slave     tx,
   output logic              txd,
   output logic              busy
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] div_q, div_d, pend_val_q, pend_val_d;
   logic              pend_q, pend_d, baud_set_q, baud_set_d;
   logic              ready_q, ready_d, txd_q, txd_d, par_q, par_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              accept, bit_end;

   assign accept      = tx.tx_valid && ready_q;
   assign tx.tx_ready = ready_q;
   assign txd         = txd_q;
   assign busy        = (state_q != ST_IDLE);
   assign baud_set    = baud_set_q;

   // div_d feeds the counter so a latch on the accept edge sets the new rate
   // for that very frame; during a frame div_d equals div_q.
   uart_baud_tick u_tick (
      .clk       (clk),
      .rst       (rst),
      .divisor_i (div_d),
      .run_i     (state_q != ST_IDLE),
      .restart_i (accept),
      .bit_end_o (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      baud_set_d = baud_set_q;
      shift_d    = shift_q;
      par_d      = par_q;
      txd_d      = txd_q;
      bit_cnt_d  = bit_cnt_q;

      // Divisor only changes in IDLE; latches during a frame are parked
      // (last one wins) and applied on the first idle cycle.
      if (state_q == ST_IDLE) begin
         if (latch_baud) begin
            div_d      = baud_word;
            baud_set_d = 1'b1;
            pend_d     = 1'b0;
         end else if (pend_q) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
         end
      end else if (latch_baud) begin
         pend_val_d = baud_word;
         pend_d     = 1'b1;
      end

      case (state_q)
         ST_IDLE: if (accept) begin
            state_d = ST_START;
            shift_d = tx.tx_data;
            par_d   = calc_parity(tx.tx_data, DATA_BITS, PARITY);
            txd_d   = 1'b0;
         end
         ST_START: if (bit_end) begin
            state_d   = ST_DATA;
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = '0;
         end
         ST_DATA: if (bit_end) begin
            if (bit_cnt_q == LAST_DATA) begin
               bit_cnt_d = '0;
               if (PARITY != int'(PAR_NONE)) begin
                  state_d = ST_PARITY;
                  txd_d   = par_q;
               end else begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end
            end else begin
               txd_d     = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         ST_PARITY: if (bit_end) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
         end
         ST_STOP: if (bit_end) begin
            if (bit_cnt_q == LAST_STOP) state_d = ST_IDLE;
            else                        bit_cnt_d = bit_cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE) && baud_set_d && !pend_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         div_q      <= '1;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         baud_set_q <= 1'b0;
         ready_q    <= 1'b0;
         txd_q      <= 1'b1;
         par_q      <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         baud_set_q <= baud_set_d;
         ready_q    <= ready_d;
         txd_q      <= txd_d;
         par_q      <= par_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

endmodule
